// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage feeding a combinational ALU, with register file and write-back.
// Define ALU_FWD_EN for EX-to-issue forwarding; otherwise dependent ops are interlocked.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_ra,
    input  logic [REG_AW-1:0] in_rb,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic              stall,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    output logic              res_valid,
    output logic [REG_AW-1:0] res_rd,
    output logic [DATA_W-1:0] res_data
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] rf [NREG];
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] imm_ext;
    logic              hazard;
    logic              accept;
    logic              wb;

    assign imm_ext = DATA_W'(in_imm);

`ifdef ALU_FWD_EN
    assign src_a  = (ex_valid && ex_rd == in_ra && in_ra != '0) ? alu_res : rf[in_ra];
    assign src_b  = (ex_valid && ex_rd == in_rb && in_rb != '0) ? alu_res : rf[in_rb];
    assign hazard = 1'b0;
`else
    assign src_a  = rf[in_ra];
    assign src_b  = rf[in_rb];
    assign hazard = ex_valid && ex_rd != '0 &&
                    (ex_rd == in_ra || (!in_use_imm && ex_rd == in_rb));
`endif

    assign in_ready = !stall && !hazard;
    assign accept   = in_valid && in_ready;
    assign wb       = ex_valid && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_rd    <= '0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
        end else if (!stall) begin
            ex_valid <= accept;
            if (accept) begin
                ex_rd  <= in_rd;
                alu_op <= in_op;
                alu_a  <= src_a;
                alu_b  <= in_use_imm ? imm_ext : src_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= wb;
            if (wb) begin
                res_rd   <= ex_rd;
                res_data <= alu_res;
            end
        end
    end

    // r0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb && ex_rd != '0) begin
            rf[ex_rd] <= alu_res;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and random-stream bench for alu_issue_stage with a behavioural ALU.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_rd;
    logic [3:0]  in_ra;
    logic [3:0]  in_rb;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic        stall;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        res_valid;
    logic [3:0]  res_rd;
    logic [31:0] res_data;

    int checks = 0;
    int errors = 0;
    bit rnd_on = 0;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t         q[$];
    logic [31:0] mreg[16];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return b - a;
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h5:    return a ^ b;
            4'hC:    return {31'd0, a < b};
            4'hD:    return {31'd0, $signed(a) < $signed(b)};
            4'hE:    return {31'd0, a == b};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res = alu_f(alu_op, alu_a, alu_b);

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .stall(stall),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data)
    );

    // Scoreboard for the random stream: write-backs must appear in issue order
    always @(negedge clk) begin
        if (rnd_on && res_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rnd_extra_wb: got rd=%0d data=%h, none expected",
                         res_rd, res_data);
            end else begin
                wb_t e;
                e = q.pop_front();
                if (res_rd !== e.rd || res_data !== e.data) begin
                    errors++;
                    $display("FAIL rnd_wb: got rd=%0d data=%h, expected rd=%0d data=%h",
                             res_rd, res_data, e.rd, e.data);
                end
            end
        end
    end

    // Present one op and hold it until accepted; returns at the negedge after the accept edge
    task automatic send(input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [15:0] imm, input logic ui, input bit rnd);
        bit done = 0;
        in_op = op; in_rd = rd; in_ra = ra; in_rb = rb;
        in_imm = imm; in_use_imm = ui; in_valid = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            if (rnd) stall = ($urandom_range(0, 3) == 0);
            #1;
            if (in_ready) begin
                done = 1;
                if (rnd) begin
                    wb_t e;
                    e.rd = rd;
                    e.data = alu_f(op, mreg[ra], ui ? {16'd0, imm} : mreg[rb]);
                    if (rd != 4'd0) mreg[rd] = e.data;
                    q.push_back(e);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: op never accepted, in_ready=%b", in_ready);
        end
    endtask

    task automatic read_reg(input logic [3:0] r, output logic vld,
                            output logic [31:0] d);
        send(4'h4, 4'd0, r, 4'd0, 16'd0, 1'b1, 0);
        @(negedge clk);
        #1;
        vld = res_valid && res_rd == 4'd0;
        d = res_data;
    endtask

    task automatic test_reset;
        logic        v;
        logic [31:0] d;
        int          n;
        if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_ex: op=%h a=%h b=%h, expected all 0", alu_op, alu_a, alu_b);
        end
        checks++;
        if (res_valid !== 1'b0 || res_rd !== 4'd0 || res_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_res: v=%b rd=%0d d=%h, expected all 0",
                     res_valid, res_rd, res_data);
        end
        checks++;
        send(4'h0, 4'd7, 4'd0, 4'd0, 16'd9, 1'b1, 0);
        checks++;
        if (alu_b !== 32'd9) begin
            errors++;
            $display("FAIL reset_pre_b: got %h, expected 00000009", alu_b);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (alu_b !== 32'd0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: b=%h v=%b, expected 0/0", alu_b, res_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 1", in_ready);
        end
        n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (res_valid) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL reset_discard: %0d write-backs seen, expected 0", n);
        end
        read_reg(4'd7, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL reset_r7: v=%b d=%h, expected 1/00000000", v, d);
        end
    endtask

    task automatic test_back_to_back;
        int          t1 = -1;
        int          t2 = -1;
        int          bub = 0;
        bit          pend = 1;
        logic [31:0] d1 = '0;
        logic [31:0] d2 = '0;
        in_op = 4'h0; in_rd = 4'd1; in_ra = 4'd0; in_rb = 4'd0;
        in_imm = 16'd5; in_use_imm = 1'b1; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready0: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_rd = 4'd2; in_ra = 4'd1; in_imm = 16'd7;
        for (int c = 1; c < 8; c++) begin
            #1;
            if (res_valid && res_rd == 4'd1) begin t1 = c; d1 = res_data; end
            if (res_valid && res_rd == 4'd2) begin t2 = c; d2 = res_data; end
            if (pend) begin
                if (in_ready) pend = 0;
                else bub++;
            end
            @(posedge clk);
            @(negedge clk);
            if (!pend) in_valid = 1'b0;
        end
        checks++;
        if (d1 !== 32'd5 || d2 !== 32'd12) begin
            errors++;
            $display("FAIL b2b_data: r1=%h r2=%h, expected 5/c", d1, d2);
        end
`ifdef ALU_FWD_EN
        checks++;
        if (bub != 0 || t2 - t1 != 1) begin
            errors++;
            $display("FAIL b2b_timing: bubbles=%0d gap=%0d, expected 0/1", bub, t2 - t1);
        end
`else
        checks++;
        if (bub != 1 || t2 - t1 != 2) begin
            errors++;
            $display("FAIL b2b_timing: bubbles=%0d gap=%0d, expected 1/2", bub, t2 - t1);
        end
`endif
    endtask

    task automatic test_r0;
        logic        v;
        logic [31:0] d;
        send(4'h4, 4'd0, 4'd0, 4'd0, 16'hFFFF, 1'b1, 0);
        @(negedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_rd !== 4'd0 || res_data !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL r0_wb: v=%b rd=%0d d=%h, expected 1/0/0000ffff",
                     res_valid, res_rd, res_data);
        end
        read_reg(4'd0, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL r0_read: v=%b d=%h, expected 1/00000000", v, d);
        end
    endtask

    task automatic test_stall;
        logic [3:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] d = '0;
        int          n = 0;
        send(4'h0, 4'd8, 4'd0, 4'd0, 16'h0123, 1'b1, 0);
        stall = 1'b1;
        #1;
        op0 = alu_op; a0 = alu_a; b0 = alu_b;
        checks++;
        if (b0 !== 32'h123) begin
            errors++;
            $display("FAIL stall_ex: b=%h, expected 00000123", b0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (alu_op !== op0 || alu_a !== a0 || alu_b !== b0 ||
                res_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: op=%h a=%h b=%h v=%b rdy=%b, expected %h/%h/%h/0/0",
                         alu_op, alu_a, alu_b, res_valid, in_ready, op0, a0, b0);
            end
        end
        stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (res_valid && res_rd == 4'd8) begin n++; d = res_data; end
        end
        checks++;
        if (n != 1 || d !== 32'h123) begin
            errors++;
            $display("FAIL stall_release: %0d write-backs data=%h, expected 1/00000123", n, d);
        end
    endtask

    task automatic test_compare;
        send(4'h0, 4'd3, 4'd0, 4'd0, 16'd10, 1'b1, 0);
        @(negedge clk);
        send(4'h0, 4'd4, 4'd0, 4'd0, 16'd10, 1'b1, 0);
        @(negedge clk);
        send(4'hE, 4'd5, 4'd3, 4'd4, 16'd0, 1'b0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_rd !== 4'd5 || res_data !== 32'd1) begin
            errors++;
            $display("FAIL cmp_eq: v=%b rd=%0d d=%h, expected 1/5/00000001",
                     res_valid, res_rd, res_data);
        end
        send(4'h2, 4'd6, 4'd3, 4'd4, 16'd0, 1'b0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_rd !== 4'd6 || res_data !== 32'd0) begin
            errors++;
            $display("FAIL cmp_rsub: v=%b rd=%0d d=%h, expected 1/6/00000000",
                     res_valid, res_rd, res_data);
        end
    endtask

    task automatic test_random;
        logic [3:0]  ops[9];
        logic        v;
        logic [31:0] d;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hC, 4'hD, 4'hE};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
        q.delete();
        rnd_on = 1;
        for (int i = 0; i < 200; i++) begin
            send(ops[$urandom_range(0, 8)], 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 16'($urandom), 1'($urandom_range(0, 1)), 1);
        end
        stall = 1'b0;
        repeat (4) @(negedge clk);
        rnd_on = 0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: %0d write-backs missing, expected 0", q.size());
        end
        for (int r = 0; r < 16; r++) begin
            read_reg(4'(r), v, d);
            checks++;
            if (v !== 1'b1 || d !== mreg[r]) begin
                errors++;
                $display("FAIL rnd_reg r%0d: v=%b d=%h, expected 1/%h", r, v, d, mreg[r]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0;
        in_imm = '0; in_use_imm = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready0: got %b, expected 1", in_ready);
        end
        test_reset;
        test_back_to_back;
        test_r0;
        test_stall;
        test_compare;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
